seg_scan_display: RTL
=====================

# seg_scan_display

Memory-mapped, hardware-scanned multiplexed 7-segment display controller on the CPU peripheral bus. Software writes hex digit values, a decimal-point mask and control bits; the block time-multiplexes the digits itself, driving active-low anodes and segments, so the CPU no longer bit-bangs digit select and segment patterns. It generalises the single fixed 12-bit display control register to N digits, with a scan engine, leading-zero blanking and register readback.

## Interface
- NUM_DIGITS, 4, number of digits, legal 1..8.
- SCAN_DIV, 50000, clk cycles each digit is displayed, legal ≥ 1.
- BASE_ADDR, 32'h4000_0010, byte address of register DATA; CTRL at +4, STATUS at +8.

- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- MemRead  input  1  bus read strobe.
- MemWrite  input  1  bus write strobe.
- MemBus_Address  input  32  byte address; full 32-bit compare.
- MemBus_Write_Data  input  32  write data.
- MemBus_Read_Data  output  32  read data, combinational.
- an  output  NUM_DIGITS  digit anodes, active-low, registered.
- seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
- dp  output  1  decimal point, active-low, registered.

## Operation
- DATA (RW): 4 bits per digit; digit i = bits [4i+3:4i]; bits at and above 4·NUM_DIGITS read 0, writes to them ignored.
- CTRL (RW): bit0 EN, bit1 LZB (leading-zero blanking), bits [8+NUM_DIGITS-1:8] DP mask (bit 8+i lights dp on digit i); all other bits read 0.
- STATUS (RO): bits [2:0] current scan index, bit 8 = EN; writes ignored.
- Write: register updated at the clk edge where MemWrite=1 and address matches exactly. Unmapped addresses ignored.
- Read: MemBus_Read_Data = register value when MemRead=1 and address matches, else 32'h0. MemRead and MemWrite to the same register in one cycle: read returns pre-write value.
- Scan engine: prescaler counts 0..SCAN_DIV-1 while EN=1; on the edge where prescaler = SCAN_DIV-1 it returns to 0 and index advances, NUM_DIGITS-1 wraps to 0. EN=0: prescaler and index held at 0.
- Decode (hex, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E.
- LZB=1: digit i blank (seg=7F, dp still per mask) when every digit j ≥ i has value 0 and i ≠ 0; digit 0 is never blanked.
- Output register, each edge: EN=0 → an all ones, seg=7F, dp=1. EN=1 → an = ~(1<<index), seg = decode/blank of digit[index], dp = ~mask[index].
- Reset: DATA=0, CTRL=0, prescaler=0, index=0, an all ones, seg=7F, dp=1; MemBus_Read_Data follows combinational rule (0 when idle).

## Timing
- Output latency: one edge after any change of index, DATA or CTRL.
- EN written 1 at edge E0 → digit 0 visible after E1, held SCAN_DIV cycles; each subsequent digit visible for exactly SCAN_DIV cycles.
- SCAN_DIV=1: index advances every enabled cycle.
- EN cleared at edge E0 → outputs blank after E1; index reads 0 from E0+1 onward.
- DATA write mid-scan: current digit's new value appears one edge later; scan phase unaffected.
- Reset asserted mid-scan: all state and outputs return to reset values immediately, asynchronously.

## Test plan
- Reset: assert reset mid-scan → an=4'hF, seg=7F, dp=1, DATA/CTRL read 0 immediately.
- Readback: write DATA=32'hFFFF_1234 (NUM_DIGITS=4) → read DATA = 32'h0000_1234; write STATUS=FFFF_FFFF → STATUS unchanged; read unmapped 0x4000_0020 → 0.
- Scan (SCAN_DIV=3): DATA=1234, CTRL=1 → an sequence E,D,B,7 each 3 cycles, seg 19,30,24,79 respectively, wrap to E after 12 cycles.
- LZB: DATA=0005, CTRL=3 → digit 0 seg=12, digits 1–3 seg=7F; DATA=0000 → digit 0 seg=40, others 7F.
- DP: CTRL=32'h0000_0501 → dp=0 on digits 0 and 2 only, dp=1 on digits 1 and 3.
- Simultaneous: MemRead+MemWrite to DATA with old 1111, new 2222 → read returns 1111 that cycle, 2222 next; clear EN mid-digit-2 → outputs blank next edge, STATUS index 0.

Source files
------------

// File: rtl/seg_scan_display_if.sv
// Peripheral bus bundle between the CPU and the 7-segment scan controller.
// Signals: MemRead/MemWrite strobes, 32-bit byte address, write data and
// combinational read data. master = CPU side, slave = peripheral side.
interface seg_scan_display_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemBus_Address;
    logic [31:0] MemBus_Write_Data;
    logic [31:0] MemBus_Read_Data;

    modport master (
        output MemRead,
        output MemWrite,
        output MemBus_Address,
        output MemBus_Write_Data,
        input  MemBus_Read_Data
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  MemBus_Address,
        input  MemBus_Write_Data,
        output MemBus_Read_Data
    );
endinterface

// File: rtl/seg_scan_display.sv
// Memory-mapped, hardware-scanned multiplexed 7-segment display controller.
// Registers: DATA (BASE_ADDR, 4 bits per digit), CTRL (+4: EN, LZB, DP mask),
// STATUS (+8, read-only: scan index, EN).
// Ports:
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   bus          - CPU peripheral bus (slave modport), combinational read data
//   an           - digit anodes, active-low, registered
//   seg          - segments {g,f,e,d,c,b,a}, active-low, registered
//   dp           - decimal point, active-low, registered
module seg_scan_display #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0010
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scan_display_if.slave     bus,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);
    localparam int unsigned DataBits = 4 * NUM_DIGITS;
    localparam int unsigned DivW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [DivW-1:0] PreLast  = DivW'(SCAN_DIV - 1);
    localparam logic [2:0]      IdxLast  = 3'(NUM_DIGITS - 1);
    localparam logic [31:0]     DataMask = 32'((64'h1 << DataBits) - 64'h1);
    localparam logic [31:0]     CtrlMask = 32'h3 | 32'(((64'h1 << NUM_DIGITS) - 64'h1) << 8);
    localparam logic [31:0]     CtrlAddr = BASE_ADDR + 32'd4;
    localparam logic [31:0]     StatAddr = BASE_ADDR + 32'd8;

    logic [31:0]     dataReg;
    logic [31:0]     ctrlReg;
    logic [DivW-1:0] prescale;
    logic [2:0]      scanIdx;
    logic            en;
    logic            lzb;
    logic            hitData;
    logic            hitCtrl;
    logic            hitStat;
    logic [3:0]      curDigit;
    logic            curDp;
    logic            curBlank;
    logic [31:0]     upperDigits;

    assign en  = ctrlReg[0];
    assign lzb = ctrlReg[1];

    assign hitData = (bus.MemBus_Address == BASE_ADDR);
    assign hitCtrl = (bus.MemBus_Address == CtrlAddr);
    assign hitStat = (bus.MemBus_Address == StatAddr);

    // Hex digit to active-low segment pattern.
    function automatic logic [6:0] hexToSeg(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Register writes; unimplemented bits are masked so they always read 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataReg <= 32'h0;
            ctrlReg <= 32'h0;
        end else if (bus.MemWrite) begin
            if (hitData) dataReg <= bus.MemBus_Write_Data & DataMask;
            if (hitCtrl) ctrlReg <= bus.MemBus_Write_Data & CtrlMask;
        end
    end

    // Combinational readback; a same-cycle write is seen on the next cycle.
    always_comb begin
        bus.MemBus_Read_Data = 32'h0;
        if (bus.MemRead) begin
            if (hitData)      bus.MemBus_Read_Data = dataReg;
            else if (hitCtrl) bus.MemBus_Read_Data = ctrlReg;
            else if (hitStat) bus.MemBus_Read_Data = {23'h0, en, 5'h0, scanIdx};
        end
    end

    // Scan engine: prescaler paces the digit index; both parked at 0 while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            scanIdx  <= 3'd0;
        end else if (!en) begin
            prescale <= '0;
            scanIdx  <= 3'd0;
        end else if (prescale == PreLast) begin
            prescale <= '0;
            scanIdx  <= (scanIdx == IdxLast) ? 3'd0 : scanIdx + 3'd1;
        end else begin
            prescale <= prescale + DivW'(1);
        end
    end

    // Select current digit and DP bit; blank when this and all higher digits are zero.
    always_comb begin
        curDigit = 4'h0;
        curDp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scanIdx == 3'(i)) begin
                curDigit = dataReg[4*i +: 4];
                curDp    = ctrlReg[8+i];
            end
        end
        upperDigits = dataReg >> {scanIdx, 2'b00};
        curBlank    = lzb && (scanIdx != 3'd0) && (upperDigits == 32'h0);
    end

    // Output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (!en) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << scanIdx);
            seg <= curBlank ? 7'h7F : hexToSeg(curDigit);
            dp  <= ~curDp;
        end
    end
endmodule
